nanov_muldiv: RTL

- Bit-serial RV32M/RV64M multiply/divide unit, successor to the fixed 16-bit multiplier.
- Parametrised in XLEN. Supports all eight M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Operands arrive LSB-first one bit per clock, in lockstep with the core's serial counter. The result leaves the same way.
- Sits beside the ALU in nanoV_core and drives data_rd when is_mul is set.

---
 rtl/nanov_muldiv_pkg.sv | 39 +++
 rtl/nanov_muldiv_if.sv | 21 ++
 rtl/nanov_muldiv_serial_neg.sv | 29 ++
 rtl/nanov_muldiv.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_muldiv_pkg.sv
// Shared definitions for the bit-serial RV32M/RV64M multiply/divide unit:
// funct3 op encodings, controller states and operand-class helpers.
package nanov_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_e;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Multiply ops that return the upper half of the product
  function automatic logic op_is_hi(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/nanov_muldiv_if.sv
// Serial handshake between the core (master) and the mul/div unit (slave).
interface nanov_muldiv_if;
  logic       start;
  logic [2:0] op;
  logic       a_in;
  logic       b_in;
  logic       busy;
  logic       done;
  logic       result_out;
  logic       result_shift;

  modport master (
    output start, op, a_in, b_in, result_shift,
    input  busy, done, result_out
  );

  modport slave (
    input  start, op, a_in, b_in, result_shift,
    output busy, done, result_out
  );
endinterface

// File: rtl/nanov_muldiv_serial_neg.sv
// Bit-serial two's-complement negator: out = ~in + carry, LSB first.
// init selects carry_init for the first bit of a word; en advances the
// internal carry so a stalled stream keeps its current output bit.
module nanov_muldiv_serial_neg (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic init,
  input  logic carry_init,
  input  logic bit_in,
  output logic bit_out
);

  logic carry_q;
  logic carry;

  assign carry   = init ? carry_init : carry_q;
  assign bit_out = ~bit_in ^ carry;

  // Carry ripples to the next bit only while the stream advances
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= ~bit_in & carry;
    end
  end

endmodule

// File: rtl/nanov_muldiv.sv
// Bit-serial M-extension unit. Operands stream in LSB first, are turned
// into magnitudes, an unsigned shift-add multiply or restoring divide runs
// for XLEN cycles, and the selected word streams out with its sign applied.
//
// state | meaning
// IDLE  | waiting for start; bit 0 and op are taken in the start cycle
// LOAD  | shifting in operand bits 1..XLEN-1 (raw and negated copies)
// CALC  | XLEN iterations of shift-add or restoring divide
// OUT   | done=1, result bit valid, advances on result_shift
module nanov_muldiv
  import nanov_muldiv_pkg::*;
#(
  parameter  int XLEN     = 32,
  localparam int CNT_BITS = $clog2(XLEN)
) (
  input logic            clk,
  input logic            rstn,
  nanov_muldiv_if.slave  bus
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(XLEN - 1);

  state_e state_q, state_d;

  logic [CNT_BITS-1:0] cnt_q;
  logic [2:0]          op_q;
  // reg_x : a stream in LOAD, then multiplicand / divisor in CALC
  // reg_xn: negated a stream in LOAD, then the outgoing result word in OUT
  // reg_y : b stream in LOAD, then multiplier->product low / dividend->quotient
  // reg_yn: negated b stream
  logic [XLEN-1:0]     reg_x, reg_xn, reg_y, reg_yn;
  logic [XLEN:0]       reg_hi;
  logic                sa_q, sb_q, bz_q, lo_zero_q, res_neg_q;

  logic first, load_last, calc_last, out_last, out_shift;
  logic a_neg_bit, b_neg_bit, r_neg_bit;

  assign first     = (state_q == IDLE) && bus.start;
  assign load_last = (state_q == LOAD) && (cnt_q == CNT_LAST);
  assign calc_last = (state_q == CALC) && (cnt_q == CNT_LAST);
  assign out_shift = (state_q == OUT) && bus.result_shift;
  assign out_last  = out_shift && (cnt_q == CNT_LAST);

  // Operand capture: raw and negated streams side by side, since the sign
  // bit only arrives with the last LOAD bit
  logic            capture;
  logic [XLEN-1:0] a_raw_nx, a_neg_nx, b_raw_nx, b_neg_nx, a_mag, b_mag;
  logic            sa_nx, sb_nx, bz_nx;

  assign capture  = first || (state_q == LOAD);
  assign a_raw_nx = {bus.a_in, reg_x[XLEN-1:1]};
  assign a_neg_nx = {a_neg_bit, reg_xn[XLEN-1:1]};
  assign b_raw_nx = {bus.b_in, reg_y[XLEN-1:1]};
  assign b_neg_nx = {b_neg_bit, reg_yn[XLEN-1:1]};
  assign sa_nx    = bus.a_in & a_signed(op_q);
  assign sb_nx    = bus.b_in & b_signed(op_q);
  assign a_mag    = sa_nx ? a_neg_nx : a_raw_nx;
  assign b_mag    = sb_nx ? b_neg_nx : b_raw_nx;
  // b magnitude is zero exactly when every raw b bit is zero
  assign bz_nx    = bz_q & ~bus.b_in;

  nanov_muldiv_serial_neg u_neg_a (
    .clk        (clk),
    .rstn       (rstn),
    .en         (capture),
    .init       (first),
    .carry_init (1'b1),
    .bit_in     (bus.a_in),
    .bit_out    (a_neg_bit)
  );

  nanov_muldiv_serial_neg u_neg_b (
    .clk        (clk),
    .rstn       (rstn),
    .en         (capture),
    .init       (first),
    .carry_init (1'b1),
    .bit_in     (bus.b_in),
    .bit_out    (b_neg_bit)
  );

  // One CALC iteration: shift-add for multiply, compare-subtract for divide
  logic [XLEN:0]   mul_sum, rem_sh, hi_nx;
  logic [XLEN+1:0] rem_diff;
  logic [XLEN-1:0] y_nx;
  logic            lo_zero_nx;

  always_comb begin
    mul_sum    = reg_hi + (reg_y[0] ? {1'b0, reg_x} : {(XLEN+1){1'b0}});
    rem_sh     = {reg_hi[XLEN-1:0], reg_y[XLEN-1]};
    rem_diff   = {1'b0, rem_sh} - {2'b00, reg_x};
    hi_nx      = reg_hi;
    y_nx       = reg_y;
    lo_zero_nx = lo_zero_q;
    if (op_is_div(op_q)) begin
      hi_nx = rem_diff[XLEN+1] ? rem_sh : rem_diff[XLEN:0];
      y_nx  = {reg_y[XLEN-2:0], ~rem_diff[XLEN+1]};
    end else begin
      // each product low bit retires into reg_y here, so track "low == 0"
      hi_nx      = {1'b0, mul_sum[XLEN:1]};
      y_nx       = {mul_sum[0], reg_y[XLEN-1:1]};
      lo_zero_nx = lo_zero_q & ~mul_sum[0];
    end
  end

  // Word and sign chosen from the final iteration's values
  logic [XLEN-1:0] res_word;
  logic            res_neg_nx;
  logic            res_carry_init;

  always_comb begin
    res_word   = y_nx;
    res_neg_nx = 1'b0;
    case (op_q)
      OP_MUL: begin
        res_word   = y_nx;
        res_neg_nx = sa_q ^ sb_q;
      end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        res_word   = hi_nx[XLEN-1:0];
        res_neg_nx = sa_q ^ sb_q;
      end
      OP_DIV, OP_DIVU: begin
        res_word   = y_nx;
        res_neg_nx = (sa_q ^ sb_q) & ~bz_q;
      end
      default: begin
        res_word   = hi_nx[XLEN-1:0];
        res_neg_nx = sa_q;
      end
    endcase
  end

  // Negating a 2*XLEN product: the high half only gets the +1 when the low
  // half is all zeros
  assign res_carry_init = op_is_hi(op_q) ? lo_zero_q : 1'b1;

  nanov_muldiv_serial_neg u_neg_r (
    .clk        (clk),
    .rstn       (rstn),
    .en         (out_shift),
    .init       (cnt_q == '0),
    .carry_init (res_carry_init),
    .bit_in     (reg_xn[0]),
    .bit_out    (r_neg_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (load_last) state_d = CALC;
      CALC:    if (calc_last) state_d = OUT;
      OUT:     if (out_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and datapath registers, advanced per state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      op_q      <= '0;
      reg_x     <= '0;
      reg_xn    <= '0;
      reg_y     <= '0;
      reg_yn    <= '0;
      reg_hi    <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      bz_q      <= 1'b0;
      lo_zero_q <= 1'b0;
      res_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q  <= CNT_BITS'(1);
            op_q   <= bus.op;
            reg_x  <= a_raw_nx;
            reg_xn <= a_neg_nx;
            reg_y  <= b_raw_nx;
            reg_yn <= b_neg_nx;
            bz_q   <= ~bus.b_in;
          end
        end
        LOAD: begin
          cnt_q <= cnt_q + CNT_BITS'(1);
          bz_q  <= bz_nx;
          if (load_last) begin
            sa_q      <= sa_nx;
            sb_q      <= sb_nx;
            reg_x     <= op_is_div(op_q) ? b_mag : a_mag;
            reg_y     <= op_is_div(op_q) ? a_mag : b_mag;
            reg_hi    <= '0;
            lo_zero_q <= 1'b1;
          end else begin
            reg_x  <= a_raw_nx;
            reg_xn <= a_neg_nx;
            reg_y  <= b_raw_nx;
            reg_yn <= b_neg_nx;
          end
        end
        CALC: begin
          cnt_q     <= cnt_q + CNT_BITS'(1);
          reg_hi    <= hi_nx;
          reg_y     <= y_nx;
          lo_zero_q <= lo_zero_nx;
          if (calc_last) begin
            reg_xn    <= res_word;
            res_neg_q <= res_neg_nx;
          end
        end
        OUT: begin
          if (bus.result_shift) begin
            cnt_q  <= cnt_q + CNT_BITS'(1);
            reg_xn <= {1'b0, reg_xn[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_q == LOAD) || (state_q == CALC);
  assign bus.done       = (state_q == OUT);
  assign bus.result_out = (state_q == OUT) && (res_neg_q ? r_neg_bit : reg_xn[0]);

endmodule
